// File: rtl/fsm_state_coverage_monitor.sv
// Runtime FSM coverage monitor: samples a state bus, records visited encodings,
// counts entries into each state and latches the first illegal encoding seen.
module fsm_state_coverage_monitor #(
    parameter int unsigned               STATE_W    = 2,
    parameter int unsigned               CNT_W      = 16,
    parameter logic [(2**STATE_W)-1:0]   LEGAL_MASK = 4'b0111
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mon_en_i,
    input  logic                    clear_i,
    input  logic [STATE_W-1:0]      state_in_i,
    input  logic                    rd_req_i,
    input  logic [STATE_W-1:0]      rd_addr_i,
    output logic                    rd_valid_o,
    output logic [CNT_W-1:0]        rd_data_o,
    output logic [(2**STATE_W)-1:0] visited_o,
    output logic [(2**STATE_W)-1:0] unvisited_legal_o,
    output logic                    illegal_flag_o,
    output logic [STATE_W-1:0]      illegal_state_o
);

    localparam int unsigned      NS      = 2 ** STATE_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {StIdle, StFirst, StTrack} fsm_e;

    fsm_e               fsm_q;
    logic [CNT_W-1:0]   hits_q [NS];
    logic [STATE_W-1:0] prev_q;
    logic [NS-1:0]      visited_q;
    logic               illegal_flag_q;
    logic [STATE_W-1:0] illegal_state_q;
    logic               rd_valid_q;
    logic [CNT_W-1:0]   rd_data_q;

    logic               sample;
    logic               entry;
    logic               bump;
    logic               illegal_now;
    logic [CNT_W-1:0]   hit_cur;
    logic [CNT_W-1:0]   hit_d;

    always_comb begin
        // clear discards any sample presented in the same cycle
        sample      = mon_en_i & ~clear_i;
        entry       = (fsm_q != StTrack);
        bump        = sample & (entry | (state_in_i != prev_q));
        illegal_now = sample & ~LEGAL_MASK[state_in_i];
        hit_cur     = hits_q[state_in_i];
        hit_d       = (hit_cur == CNT_MAX) ? hit_cur : hit_cur + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q           <= StIdle;
            prev_q          <= '0;
            visited_q       <= '0;
            illegal_flag_q  <= 1'b0;
            illegal_state_q <= '0;
            rd_valid_q      <= 1'b0;
            rd_data_q       <= '0;
            for (int i = 0; i < int'(NS); i++) begin
                hits_q[i] <= '0;
            end
        end else begin
            rd_valid_q <= rd_req_i;
            if (rd_req_i) begin
                rd_data_q <= hits_q[rd_addr_i];
            end

            if (clear_i) begin
                fsm_q           <= StIdle;
                prev_q          <= '0;
                visited_q       <= '0;
                illegal_flag_q  <= 1'b0;
                illegal_state_q <= '0;
                for (int i = 0; i < int'(NS); i++) begin
                    hits_q[i] <= '0;
                end
            end else if (sample) begin
                // first sample after idle is an entry even if it matches prev_q
                fsm_q                 <= StTrack;
                prev_q                <= state_in_i;
                visited_q[state_in_i] <= 1'b1;
                if (bump) begin
                    hits_q[state_in_i] <= hit_d;
                end
                if (illegal_now) begin
                    illegal_flag_q <= 1'b1;
                    if (!illegal_flag_q) begin
                        illegal_state_q <= state_in_i;
                    end
                end
            end
        end
    end

    assign rd_valid_o        = rd_valid_q;
    assign rd_data_o         = rd_data_q;
    assign visited_o         = visited_q;
    assign unvisited_legal_o = LEGAL_MASK & ~visited_q;
    assign illegal_flag_o    = illegal_flag_q;
    assign illegal_state_o   = illegal_state_q;

endmodule

// File: tb/tb_fsm_state_coverage_monitor.sv
// Bench for fsm_state_coverage_monitor: vector table through a scoreboard queue,
// plus hand sequences for saturation, async reset and clear.
module tb_fsm_state_coverage_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mon_en;
    logic        clear;
    logic [1:0]  state_in;
    logic        rd_req;
    logic [1:0]  rd_addr;

    logic        rd_valid;
    logic [15:0] rd_data;
    logic [3:0]  visited;
    logic [3:0]  unvisited_legal;
    logic        illegal_flag;
    logic [1:0]  illegal_state;

    logic        rd_valid4;
    logic [3:0]  rd_data4;
    logic [3:0]  visited4;
    logic [3:0]  unvisited_legal4;
    logic        illegal_flag4;
    logic [1:0]  illegal_state4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fsm_state_coverage_monitor #(
        .STATE_W(2), .CNT_W(16), .LEGAL_MASK(4'b0111)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mon_en_i(mon_en), .clear_i(clear),
        .state_in_i(state_in), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data), .visited_o(visited),
        .unvisited_legal_o(unvisited_legal), .illegal_flag_o(illegal_flag),
        .illegal_state_o(illegal_state)
    );

    fsm_state_coverage_monitor #(
        .STATE_W(2), .CNT_W(4), .LEGAL_MASK(4'b0111)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .mon_en_i(mon_en), .clear_i(clear),
        .state_in_i(state_in), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
        .rd_valid_o(rd_valid4), .rd_data_o(rd_data4), .visited_o(visited4),
        .unvisited_legal_o(unvisited_legal4), .illegal_flag_o(illegal_flag4),
        .illegal_state_o(illegal_state4)
    );

    typedef struct {
        logic        mon;
        logic [1:0]  st;
        logic        rq;
        logic [1:0]  ra;
        logic [3:0]  vis;
        logic [3:0]  unv;
        logic        flg;
        logic [1:0]  ill;
        logic        rv;
        logic [15:0] rd;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic mon, input logic [1:0] st, input logic rq,
                       input logic [1:0] ra, input logic [3:0] vis, input logic [3:0] unv,
                       input logic flg, input logic [1:0] ill, input logic rv,
                       input logic [15:0] rd);
        vec_t v;
        v.mon = mon; v.st = st; v.rq = rq; v.ra = ra; v.vis = vis; v.unv = unv;
        v.flg = flg; v.ill = ill; v.rv = rv; v.rd = rd;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic mon, input logic [1:0] st, input logic clr,
                         input logic rq, input logic [1:0] ra);
        mon_en = mon; state_in = st; clear = clr; rd_req = rq; rd_addr = ra;
        @(posedge clk);
        #1;
        mon_en = 1'b0; clear = 1'b0; rd_req = 1'b0;
    endtask

    task automatic read2(input logic [1:0] ra, input logic [15:0] e16, input logic [3:0] e4,
                         input string name);
        drive(1'b0, 2'd0, 1'b0, 1'b1, ra);
        check({name, " rd_valid"}, 32'(rd_valid), 32'd1);
        check({name, " rd_data"}, 32'(rd_data), 32'(e16));
        check({name, " rd_data4"}, 32'(rd_data4), 32'(e4));
    endtask

    initial begin
        vec_t cur;
        vec_t e;
        rst_n = 1'b0; mon_en = 1'b0; clear = 1'b0; state_in = '0; rd_req = 1'b0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        check("reset visited", 32'(visited), 32'd0);
        check("reset unvisited_legal", 32'(unvisited_legal), 32'b0111);
        check("reset illegal_flag", 32'(illegal_flag), 32'd0);
        check("reset rd_valid", 32'(rd_valid), 32'd0);

        // mon st rq ra  vis      unv      flg ill rv rd
        add(1, 0, 0, 0, 4'b0001, 4'b0110, 0, 0, 0, 0);
        add(1, 1, 0, 0, 4'b0011, 4'b0100, 0, 0, 0, 0);
        add(1, 0, 0, 0, 4'b0011, 4'b0100, 0, 0, 0, 0);
        add(1, 1, 0, 0, 4'b0011, 4'b0100, 0, 0, 0, 0);
        add(1, 0, 0, 0, 4'b0011, 4'b0100, 0, 0, 0, 0);
        add(0, 0, 1, 0, 4'b0011, 4'b0100, 0, 0, 1, 3);
        add(0, 0, 1, 1, 4'b0011, 4'b0100, 0, 0, 1, 2);
        add(0, 0, 1, 2, 4'b0011, 4'b0100, 0, 0, 1, 0);
        add(0, 0, 1, 3, 4'b0011, 4'b0100, 0, 0, 1, 0);
        add(0, 0, 0, 0, 4'b0011, 4'b0100, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(1, 2, 0, 0, 4'b0111, 4'b0000, 0, 0, 0, 0);
        add(1, 3, 0, 0, 4'b1111, 4'b0000, 1, 3, 0, 0);
        add(1, 0, 0, 0, 4'b1111, 4'b0000, 1, 3, 0, 0);
        add(0, 0, 1, 2, 4'b1111, 4'b0000, 1, 3, 1, 1);
        add(0, 0, 1, 3, 4'b1111, 4'b0000, 1, 3, 1, 1);
        add(1, 3, 0, 0, 4'b1111, 4'b0000, 1, 3, 0, 1);
        add(0, 0, 1, 0, 4'b1111, 4'b0000, 1, 3, 1, 4);
        add(1, 1, 1, 1, 4'b1111, 4'b0000, 1, 3, 1, 2);
        add(0, 0, 1, 1, 4'b1111, 4'b0000, 1, 3, 1, 3);
        add(1, 1, 0, 0, 4'b1111, 4'b0000, 1, 3, 0, 3);
        add(0, 0, 1, 1, 4'b1111, 4'b0000, 1, 3, 1, 3);

        foreach (tbl[i]) begin
            cur = tbl[i];
            exp_q.push_back(cur);
            drive(cur.mon, cur.st, 1'b0, cur.rq, cur.ra);
            e = exp_q.pop_front();
            check($sformatf("row%0d visited", i), 32'(visited), 32'(e.vis));
            check($sformatf("row%0d unvisited", i), 32'(unvisited_legal), 32'(e.unv));
            check($sformatf("row%0d illegal_flag", i), 32'(illegal_flag), 32'(e.flg));
            check($sformatf("row%0d illegal_state", i), 32'(illegal_state), 32'(e.ill));
            check($sformatf("row%0d rd_valid", i), 32'(rd_valid), 32'(e.rv));
            check($sformatf("row%0d rd_data", i), 32'(rd_data), 32'(e.rd));
        end

        // toggle 0/1: wide counters keep counting, 4-bit copy saturates at 15
        for (int i = 0; i < 40; i++) drive(1'b1, 2'(i % 2), 1'b0, 1'b0, 2'd0);
        read2(2'd0, 16'd24, 4'd15, "sat hits0");
        read2(2'd1, 16'd23, 4'd15, "sat hits1");

        // asynchronous reset mid-run, away from the clock edge
        mon_en = 1'b1; state_in = 2'd2;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async visited", 32'(visited), 32'd0);
        check("async unvisited_legal", 32'(unvisited_legal), 32'b0111);
        check("async illegal_flag", 32'(illegal_flag), 32'd0);
        check("async illegal_state", 32'(illegal_state), 32'd0);
        check("async rd_data", 32'(rd_data), 32'd0);
        mon_en = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int a = 0; a < 4; a++) read2(2'(a), 16'd0, 4'd0, $sformatf("post-reset hits%0d", a));

        // clear beats a same-cycle sample; read of pre-clear count still returned
        drive(1'b1, 2'd0, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 2'd1, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 2'd2, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 2'd3, 1'b1, 1'b1, 2'd1);
        check("clear rd_valid", 32'(rd_valid), 32'd1);
        check("clear rd_data", 32'(rd_data), 32'd1);
        check("clear visited", 32'(visited), 32'd0);
        check("clear unvisited_legal", 32'(unvisited_legal), 32'b0111);
        check("clear illegal_flag", 32'(illegal_flag), 32'd0);
        drive(1'b1, 2'd0, 1'b0, 1'b1, 2'd0);
        check("post-clear pre-update read", 32'(rd_data), 32'd0);
        check("post-clear visited", 32'(visited), 32'b0001);
        read2(2'd0, 16'd1, 4'd1, "post-clear entry hits0");
        read2(2'd1, 16'd0, 4'd0, "post-clear hits1");
        read2(2'd3, 16'd0, 4'd0, "post-clear hits3");
        check("idle rd_valid", 32'(rd_valid), 32'd1);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
        check("idle rd_valid low", 32'(rd_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
